// File: rtl/fp_writeback_queue.sv
// fp_writeback_queue: in-order FP result queue that merges execute and load results,
// retires one entry per cycle into the register file and forwards queued values.
module fp_writeback_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    exe_valid,
  output logic                    exe_ready,
  input  logic [ADDR_WIDTH-1:0]   exe_addr,
  input  logic [DATA_WIDTH-1:0]   exe_data,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_data,
  output logic                    write_En,
  output logic [ADDR_WIDTH-1:0]   writeAddr,
  output logic [DATA_WIDTH-1:0]   data_in,
  input  logic [ADDR_WIDTH-1:0]   fwd_addr,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW:0] F1 = (CW+1)'(1);
  localparam logic [CW:0] F2 = (CW+1)'(2);
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic last_grant_q, last_grant_d;
  logic pop, win_ld, contend, exe_acc, ld_acc;
  logic [CW:0] free;
  logic [1:0] acc_n;
  // last_grant: 1 = load won the previous contention, 0 = execute
  always_comb begin
    pop = count_q != '0;
    free = DEPTH_W - {1'b0, count_q} + {{CW{1'b0}}, pop};
    win_ld = !last_grant_q;
    contend = free == F1 && exe_valid && ld_valid;
    exe_ready = free >= F2 || (free == F1 && (!ld_valid || !win_ld));
    ld_ready = free >= F2 || (free == F1 && (!exe_valid || win_ld));
    exe_acc = exe_valid && exe_ready;
    ld_acc = ld_valid && ld_ready;
    acc_n = {1'b0, exe_acc} + {1'b0, ld_acc};
    addr_d = addr_q;
    data_d = data_q;
    if (ld_acc) begin
      addr_d[tail_q] = ld_addr;
      data_d[tail_q] = ld_data;
    end
    if (exe_acc) begin
      addr_d[tail_q + PW'(ld_acc)] = exe_addr;
      data_d[tail_q + PW'(ld_acc)] = exe_data;
    end
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(acc_n);
    count_d = count_q + CW'(acc_n) - CW'(pop);
    last_grant_d = contend ? win_ld : last_grant_q;
    write_En = pop;
    writeAddr = pop ? addr_q[head_q] : '0;
    data_in = pop ? data_q[head_q] : '0;
    count = count_q;
    fwd_hit = 1'b0;
    fwd_data = '0;
    // oldest to youngest so the youngest match wins
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count_q && addr_q[head_q + PW'(i)] == fwd_addr) begin
        fwd_hit = 1'b1;
        fwd_data = data_q[head_q + PW'(i)];
      end
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      last_grant_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      last_grant_q <= last_grant_d;
    end
  always_ff @(posedge Clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_fp_writeback_queue.sv
// tb_fp_writeback_queue: table-driven directed vectors plus a pointer-wrap stream.
module tb_fp_writeback_queue;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic exe_valid = 1'b0, ld_valid = 1'b0;
  logic exe_ready, ld_ready, write_En, fwd_hit;
  logic [4:0] exe_addr = '0, ld_addr = '0, writeAddr, fwd_addr = '0;
  logic [63:0] exe_data = '0, ld_data = '0, data_in, fwd_data;
  logic [2:0] count;
  int n_cmp = 0, n_bad = 0;
  fp_writeback_queue #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .DEPTH(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_addr(exe_addr), .exe_data(exe_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .write_En(write_En), .writeAddr(writeAddr), .data_in(data_in),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    logic rst_n;
    logic ev; logic [4:0] ea; logic [63:0] ed;
    logic lv; logic [4:0] la; logic [63:0] ld;
    logic [4:0] fa;
    logic er, lr, we; logic [4:0] wa; logic [63:0] di;
    logic hit; logic [63:0] fd; logic [2:0] cnt;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t mk(logic rst_n, logic ev, logic [4:0] ea, logic [63:0] ed,
                              logic lv, logic [4:0] la, logic [63:0] ld, logic [4:0] fa,
                              logic er, logic lr, logic we, logic [4:0] wa, logic [63:0] di,
                              logic hit, logic [63:0] fd, logic [2:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.ev = ev; v.ea = ea; v.ed = ed; v.lv = lv; v.la = la; v.ld = ld;
    v.fa = fa; v.er = er; v.lr = lr; v.we = we; v.wa = wa; v.di = di;
    v.hit = hit; v.fd = fd; v.cnt = cnt;
    return v;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  initial begin
    localparam logic [63:0] TWO = 64'h4000_0000_0000_0000;
    // rst, exe{v,a,d}, ld{v,a,d}, fwd_addr | exe_rdy, ld_rdy, we, wa, di, hit, fd, count
    vq.push_back(mk(0, 0,0,0,       0,0,0,       0,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 1,3,TWO,     0,0,0,       3,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       3,  1,1,1,3,TWO,1,TWO,1));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       3,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 1,7,2,       1,7,1,       7,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       7,  1,1,1,7,1,1,2,2));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       7,  1,1,1,7,2,1,2,1));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       9,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 1,20,'h200,  1,10,'h100,  9,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 1,21,'h201,  1,11,'h101,  9,  1,1,1,10,'h100,0,0,2));
    vq.push_back(mk(1, 1,22,'h202,  1,12,'h102,  9,  1,1,1,20,'h200,0,0,3));
    vq.push_back(mk(1, 1,23,'h203,  1,13,'h103,  21, 0,1,1,11,'h101,1,'h201,4));
    vq.push_back(mk(1, 1,23,'h203,  1,14,'h104,  9,  1,0,1,21,'h201,0,0,4));
    vq.push_back(mk(1, 1,24,'h204,  1,14,'h104,  9,  0,1,1,12,'h102,0,0,4));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       23, 1,1,1,22,'h202,1,'h203,4));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       9,  1,1,1,13,'h103,0,0,3));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       9,  1,1,1,23,'h203,0,0,2));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       9,  1,1,1,14,'h104,0,0,1));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       9,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 1,2,'hA2,    1,1,'hA1,    4,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 1,4,'hA4,    1,3,'hA3,    4,  1,1,1,1,'hA1,0,0,2));
    vq.push_back(mk(0, 0,0,0,       0,0,0,       4,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(0, 0,0,0,       0,0,0,       4,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 1,5,'h55,    0,0,0,       5,  1,1,0,0,0,0,0,0));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       5,  1,1,1,5,'h55,1,'h55,1));
    vq.push_back(mk(1, 0,0,0,       0,0,0,       5,  1,1,0,0,0,0,0,0));
    foreach (vq[k]) begin
      @(negedge Clk);
      Rst_n = vq[k].rst_n;
      exe_valid = vq[k].ev; exe_addr = vq[k].ea; exe_data = vq[k].ed;
      ld_valid = vq[k].lv; ld_addr = vq[k].la; ld_data = vq[k].ld;
      fwd_addr = vq[k].fa;
      #1;
      chk($sformatf("v%0d exe_ready", k), 64'(exe_ready), 64'(vq[k].er));
      chk($sformatf("v%0d ld_ready", k), 64'(ld_ready), 64'(vq[k].lr));
      chk($sformatf("v%0d write_En", k), 64'(write_En), 64'(vq[k].we));
      chk($sformatf("v%0d writeAddr", k), 64'(writeAddr), 64'(vq[k].wa));
      chk($sformatf("v%0d data_in", k), data_in, vq[k].di);
      chk($sformatf("v%0d fwd_hit", k), 64'(fwd_hit), 64'(vq[k].hit));
      chk($sformatf("v%0d fwd_data", k), fwd_data, vq[k].fd);
      chk($sformatf("v%0d count", k), 64'(count), 64'(vq[k].cnt));
    end
    // pointer wrap: ten single execute results, each retired the cycle after acceptance
    for (int i = 0; i <= 10; i++) begin
      @(negedge Clk);
      exe_valid = i < 10; exe_addr = 5'(i); exe_data = 64'(i);
      ld_valid = 1'b0; fwd_addr = 5'd31;
      #1;
      if (i < 10) chk($sformatf("wrap%0d exe_ready", i), 64'(exe_ready), 64'd1);
      chk($sformatf("wrap%0d write_En", i), 64'(write_En), 64'(i > 0));
      chk($sformatf("wrap%0d writeAddr", i), 64'(writeAddr), i > 0 ? 64'(i - 1) : 64'd0);
      chk($sformatf("wrap%0d data_in", i), data_in, i > 0 ? 64'(i - 1) : 64'd0);
      chk($sformatf("wrap%0d count", i), 64'(count), 64'(i > 0));
    end
    @(negedge Clk);
    exe_valid = 1'b0;
    #1;
    chk("wrap_end write_En", 64'(write_En), 64'd0);
    chk("wrap_end count", 64'(count), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_writeback_queue.md
# fp_writeback_queue

Floating-point writeback stage that sits directly upstream of the FP register file and drives its write port. Accepts results from two producers, the FP execute unit and the FP load unit, over valid/ready handshakes. Holds them in an in-order queue and retires exactly one entry per cycle into the register file. Offers a combinational forwarding lookup so operand reads see results that are queued but not yet written.

## Interface
Parameters:
- DATA_WIDTH, 64, width of an FP register value
- ADDR_WIDTH, 5, register address width (32 FP registers)
- DEPTH, 4, queue entries; power of two, at least 2

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Rst_n  in  1  asynchronous, active-low reset
- exe_valid  in  1  execute unit offers a result
- exe_ready  out  1  execute result accepted this cycle when exe_valid && exe_ready
- exe_addr  in  ADDR_WIDTH  destination register of the execute result
- exe_data  in  DATA_WIDTH  execute result value
- ld_valid, ld_ready, ld_addr, ld_data  in/out/in/in  1/1/ADDR_WIDTH/DATA_WIDTH  same handshake and meaning for the load unit
- write_En  out  1  register-file write enable
- writeAddr  out  ADDR_WIDTH  register-file write address
- data_in  out  DATA_WIDTH  register-file write data
- fwd_addr  in  ADDR_WIDTH  register being read by the operand stage
- fwd_hit  out  1  a queued entry targets fwd_addr
- fwd_data  out  DATA_WIDTH  value of the youngest queued entry matching fwd_addr; 0 when fwd_hit=0
- count  out  $clog2(DEPTH)+1  current number of occupied entries

## Operation
- Circular buffer with head pointer, tail pointer and occupancy counter. An entry is {addr, data}.
- Drain: when count>0, write_En=1 and writeAddr/data_in show the head entry combinationally. Head pops at every rising edge where count>0. The register file never stalls.
- When count=0: write_En=0, writeAddr=0, data_in=0.
- Free slots this cycle: free = DEPTH - count + (count>0 ? 1 : 0). Space vacated by the current pop is reusable in the same cycle.
- Ready generation:
  - free>=2: exe_ready=ld_ready=1.
  - free==1, only one producer valid: that producer is ready.
  - free==1, both producers valid: only the round-robin winner is ready.
  - free==0: both ready=0.
- Each ready depends on the other producer's valid. No ready depends on its own valid.
- Round-robin: a 1-bit last_grant register records the producer accepted most recently under contention (free==1 with both valid). The winner is the producer other than last_grant. last_grant updates only on contended single-slot cycles.
- Dual enqueue (both accepted in one cycle): the load entry is written at tail and the execute entry at tail+1. The execute value is therefore younger and wins for equal addresses.
- Counter update per edge: count += accepted - popped, where accepted ∈{0,1,2} and popped ∈{0,1}.
- Pointers wrap modulo DEPTH.
- Forwarding is purely combinational over the valid entries, including the head being written this cycle. Among matches, the youngest (closest to tail) supplies fwd_data.
- Producers offering in the current cycle are not visible to forwarding.
- Entries carry no type tag. Order in the queue equals acceptance order.

## Timing
- Reset (Rst_n=0, asynchronous):
  - count=0, head=tail=0, last_grant=exe (so load wins the first contention).
  - write_En=0, writeAddr=0, data_in=0, fwd_hit=0, fwd_data=0.
  - exe_ready=ld_ready=1.
- Reset mid-operation discards all queued entries. write_En falls immediately, with no further register-file writes. Release is synchronous to the next Clk edge with Rst_n=1.
- Latency:
  - A result accepted at edge N appears on the write port during cycle N+1 when the queue was empty.
  - That write lands in the register file at edge N+1.
  - The result is forwardable from cycle N+1 until its pop edge.
- Throughput: 1 retire per cycle, up to 2 accepts per cycle. Sustained dual offers fill the queue at +1 per cycle until count=DEPTH. After that, only one producer is accepted per cycle, in alternation.
- Full queue with pop: free=1, so exactly one enqueue is permitted in the same cycle.

## Test plan
- Single execute write: exe_valid for one cycle with addr=3, data=0x4000000000000000 into an empty queue → exe_ready=1; next cycle write_En=1, writeAddr=3, data_in=0x4000000000000000, count=1; the cycle after that, write_En=0.
- Dual enqueue, same address: ld(addr 7, 0x1) and exe(addr 7, 0x2) in the same cycle, queue empty → both accepted; retire order is 0x1 then 0x2. While both are queued, fwd_addr=7 gives fwd_hit=1, fwd_data=0x2.
- Fill and contention: both producers valid every cycle with fresh data → count reaches 4; afterwards one accept per cycle, alternating load, exe, load. Every value retires exactly once, in acceptance order.
- Forward miss and empty: fwd_addr=9 with no matching entry → fwd_hit=0, fwd_data=0; with the queue empty, write_En=0 and writeAddr=0.
- Reset mid-stream: assert Rst_n=0 with count=3 → in the same cycle write_En=0 and count=0. After release, the first new accept is retired with no stale entries.
- Pointer wrap: stream 10 single execute results with addr=i, data=i → writeAddr sequence 0..9 with no gaps or duplicates across wrap.
